// File: rtl/conv_pe_engine.sv
// Parametrised convolution PE engine: NUM_PE signed int8 dot-product accumulators with a
// serialised, requantised OFM byte stream. Define CONV_RELU6_EN for clamp-to-[0,relu_max] activation.
module conv_pe_engine #(
  parameter int unsigned NUM_PE = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          win_len,
  input  logic [CNT_W-1:0]          num_win,
  input  logic [4:0]                shift,
  input  logic [7:0]                relu_max,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [8*LANES-1:0]        ifm_word,
  input  logic [NUM_PE*8*LANES-1:0] weight_words,
  output logic                      ofm_valid,
  input  logic                      ofm_ready,
  output logic [7:0]                ofm_data,
  output logic [$clog2(NUM_PE)-1:0] ofm_ch,
  output logic                      ofm_last,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned WORD_W = 8 * LANES;
  localparam int unsigned CH_W   = $clog2(NUM_PE);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        word_cnt, word_cnt_nx;
  logic [CNT_W-1:0]        win_cnt, win_cnt_nx;
  logic [CNT_W-1:0]        win_len_q, num_win_q;
  logic [4:0]              shift_q;
  logic signed [ACC_W-1:0] acc    [NUM_PE];
  logic signed [ACC_W-1:0] acc_nx [NUM_PE];
  logic signed [ACC_W-1:0] dot    [NUM_PE];
  logic signed [ACC_W-1:0] shifted;
  logic [CH_W-1:0]         ch_nx;
  logic [7:0]              data_nx;
  logic                    valid_nx, last_nx, load_cfg;
  logic                    hs_in, hs_out, last_word, last_ch, last_win;

`ifdef CONV_RELU6_EN
  logic [7:0] relu_max_q;

  function automatic logic [7:0] act(input logic signed [ACC_W-1:0] x, input logic [7:0] lim);
    logic [7:0] r;
    if (x < 0)                            r = '0;
    else if (x > $signed(ACC_W'(lim)))    r = lim;
    else                                  r = x[7:0];
    return r;
  endfunction
`else
  logic unused_relu_max;
  assign unused_relu_max = ^relu_max;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

  function automatic logic [7:0] act(input logic signed [ACC_W-1:0] x);
    logic [7:0] r;
    if (x < SAT_LO)      r = 8'h80;
    else if (x > SAT_HI) r = 8'h7f;
    else                 r = x[7:0];
    return r;
  endfunction
`endif

  // Per-PE dot product of the current IFM word with that PE's weight word.
  always_comb begin
    for (int p = 0; p < NUM_PE; p++) begin
      dot[p] = '0;
      for (int i = 0; i < LANES; i++) begin
        dot[p] = dot[p] + ACC_W'($signed(ifm_word[i*8 +: 8]))
                        * ACC_W'($signed(weight_words[p*WORD_W + i*8 +: 8]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    word_cnt_nx = word_cnt;
    win_cnt_nx  = win_cnt;
    ch_nx       = ofm_ch;
    load_cfg    = 1'b0;
    for (int p = 0; p < NUM_PE; p++) acc_nx[p] = acc[p];
    hs_in     = in_ready & in_valid;
    hs_out    = ofm_valid & ofm_ready;
    last_word = (word_cnt == win_len_q - CNT_W'(1));
    last_ch   = (ofm_ch == CH_W'(NUM_PE - 1));
    last_win  = (win_cnt == num_win_q - CNT_W'(1));

    case (state)
      IDLE: begin
        if (start) begin
          if (win_len == '0 || num_win == '0) begin
            state_nx = DONE;
          end else begin
            state_nx    = ACCUM;
            load_cfg    = 1'b1;
            word_cnt_nx = '0;
            win_cnt_nx  = '0;
            for (int p = 0; p < NUM_PE; p++) acc_nx[p] = '0;
          end
        end
      end
      ACCUM: begin
        if (hs_in) begin
          for (int p = 0; p < NUM_PE; p++) acc_nx[p] = acc[p] + dot[p];
          word_cnt_nx = word_cnt + CNT_W'(1);
          if (last_word) begin
            state_nx = DRAIN;
            ch_nx    = '0;
          end
        end
      end
      DRAIN: begin
        if (hs_out) begin
          if (!last_ch) begin
            ch_nx = ofm_ch + CH_W'(1);
          end else if (last_win) begin
            state_nx = DONE;
          end else begin
            state_nx    = ACCUM;
            win_cnt_nx  = win_cnt + CNT_W'(1);
            word_cnt_nx = '0;
            for (int p = 0; p < NUM_PE; p++) acc_nx[p] = '0;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Output byte is prepared from the post-update accumulators so it is ready on DRAIN entry.
    if (state_nx != DRAIN) ch_nx = '0;
    valid_nx = (state_nx == DRAIN);
    last_nx  = valid_nx && (ch_nx == CH_W'(NUM_PE - 1)) && (win_cnt_nx == num_win_q - CNT_W'(1));
    shifted  = acc_nx[ch_nx] >>> shift_q;
`ifdef CONV_RELU6_EN
    data_nx  = valid_nx ? act(shifted, relu_max_q) : 8'h00;
`else
    data_nx  = valid_nx ? act(shifted) : 8'h00;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt   <= '0;
      win_cnt    <= '0;
      win_len_q  <= '0;
      num_win_q  <= '0;
      shift_q    <= '0;
`ifdef CONV_RELU6_EN
      relu_max_q <= '0;
`endif
      for (int p = 0; p < NUM_PE; p++) acc[p] <= '0;
      in_ready   <= 1'b0;
      ofm_valid  <= 1'b0;
      ofm_data   <= '0;
      ofm_ch     <= '0;
      ofm_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      word_cnt <= word_cnt_nx;
      win_cnt  <= win_cnt_nx;
      if (load_cfg) begin
        win_len_q  <= win_len;
        num_win_q  <= num_win;
        shift_q    <= shift;
`ifdef CONV_RELU6_EN
        relu_max_q <= relu_max;
`endif
      end
      for (int p = 0; p < NUM_PE; p++) acc[p] <= acc_nx[p];
      in_ready  <= (state_nx == ACCUM);
      ofm_valid <= valid_nx;
      ofm_data  <= data_nx;
      ofm_ch    <= ch_nx;
      ofm_last  <= last_nx;
      busy      <= (state_nx != IDLE);
      done      <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_conv_pe_engine.sv
// Scoreboard bench for conv_pe_engine (NUM_PE=4, LANES=4); honours CONV_RELU6_EN in its model.
module tb_conv_pe_engine;

  localparam int NP = 4;
  localparam int LN = 4;
  localparam int AW = 32;
  localparam int CW = 16;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
    logic       last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CW-1:0]    win_len = '0;
  logic [CW-1:0]    num_win = '0;
  logic [4:0]       shift = '0;
  logic [7:0]       relu_max = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [8*LN-1:0]  ifm_word = '0;
  logic [NP*8*LN-1:0] weight_words = '0;
  logic             ofm_valid;
  logic             ofm_ready = 1'b1;
  logic [7:0]       ofm_data;
  logic [1:0]       ofm_ch;
  logic             ofm_last;
  logic             busy;
  logic             done;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_total = 0;
  int   done_cyc = 0;
  int   last_acc_cyc = 0;
  int   rdy_mode = 0;
  int   stall_left = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  conv_pe_engine #(.NUM_PE(NP), .LANES(LN), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .num_win(num_win),
    .shift(shift), .relu_max(relu_max), .in_valid(in_valid), .in_ready(in_ready),
    .ifm_word(ifm_word), .weight_words(weight_words), .ofm_valid(ofm_valid),
    .ofm_ready(ofm_ready), .ofm_data(ofm_data), .ofm_ch(ofm_ch), .ofm_last(ofm_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input bit ok, input string name, input longint got, input longint want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Reference requantisation: wrap to 32-bit accumulator, arithmetic shift, activate.
  function automatic logic [7:0] ref_act(input longint s, input int sh, input int rm);
    int     w;
    longint v;
    w = int'(s);
    v = longint'(w) >>> sh;
`ifdef CONV_RELU6_EN
    if (v < 0) return 8'd0;
    if (v > rm) return 8'(rm);
    return 8'(v);
`else
    if (rm < 0) return 8'd0;
    if (v < -128) return 8'h80;
    if (v > 127) return 8'h7f;
    return 8'(v);
`endif
  endfunction

  function automatic logic [8*LN-1:0] gen_ifm(input int pat);
    case (pat)
      0:       return $urandom;
      3:       return 32'hFFFF_FFFF;
      default: return 32'h0101_0101;
    endcase
  endfunction

  function automatic logic [NP*8*LN-1:0] gen_wt(input int pat);
    logic [NP*8*LN-1:0] w;
    logic [7:0]         b;
    case (pat)
      0: w = {$urandom, $urandom, $urandom, $urandom};
      1: for (int p = 0; p < NP; p++) w[p*32 +: 32] = {4{8'(p)}};
      default: begin
        b = (pat == 2) ? 8'h01 : (pat == 3) ? 8'h02 : (pat == 4) ? 8'h4B : 8'h19;
        w = {16{b}};
      end
    endcase
    return w;
  endfunction

  // Ready driver: always high, random, or one 3-cycle stall on channel 1.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) ofm_ready = 1'b1;
      else if (rdy_mode == 1) ofm_ready = ($urandom_range(0, 3) != 0);
      else if (ofm_valid && ofm_ch == 2'd1 && stall_left > 0) begin
        ofm_ready  = 1'b0;
        stall_left = stall_left - 1;
      end else ofm_ready = 1'b1;
    end
  end

  // Monitor: compares every presented OFM byte against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ofm_valid) begin
        chk(!in_ready, "in_ready_during_drain", in_ready, 0);
        if (exp_q.size() == 0) chk(1'b0, "ofm_unexpected", ofm_data, -1);
        else begin
          mon_e = exp_q[0];
          chk(ofm_data == mon_e.data, "ofm_data", ofm_data, mon_e.data);
          chk(ofm_ch == mon_e.ch, "ofm_ch", ofm_ch, mon_e.ch);
          chk(ofm_last == mon_e.last, "ofm_last", ofm_last, mon_e.last);
          if (ofm_ready) begin
            void'(exp_q.pop_front());
            if (mon_e.last) last_acc_cyc = cyc;
          end
        end
      end
      if (done) begin
        done_total = done_total + 1;
        done_cyc   = cyc;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk(in_ready == 1'b0, {tag, "_in_ready"}, in_ready, 0);
    chk(ofm_valid == 1'b0, {tag, "_ofm_valid"}, ofm_valid, 0);
    chk(ofm_data == 8'd0, {tag, "_ofm_data"}, ofm_data, 0);
    chk(ofm_ch == 2'd0, {tag, "_ofm_ch"}, ofm_ch, 0);
    chk(ofm_last == 1'b0, {tag, "_ofm_last"}, ofm_last, 0);
    chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
    chk(done == 1'b0, {tag, "_done"}, done, 0);
  endtask

  task automatic start_job(input int wl, input int nw, input int sh, input int rm);
    @(posedge clk);
    #1;
    start = 1'b1; win_len = CW'(wl); num_win = CW'(nw); shift = 5'(sh); relu_max = 8'(rm);
    @(posedge clk);
    #1;
    start = 1'b0;
    win_len = CW'($urandom); num_win = CW'($urandom); shift = 5'($urandom); relu_max = 8'($urandom);
    if (wl != 0 && nw != 0) begin
      chk(in_ready == 1'b1, "start_to_in_ready", in_ready, 1);
      chk(busy == 1'b1, "busy_after_start", busy, 1);
    end
  endtask

  task automatic drive_word(input logic [8*LN-1:0] ifm, input logic [NP*8*LN-1:0] wt);
    int n;
    in_valid = 1'b1; ifm_word = ifm; weight_words = wt;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk(1'b0, "in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int wl, input int nw, input int sh, input int rm,
                         input int pat, input int rdy);
    logic [8*LN-1:0]    ifm_a[$];
    logic [NP*8*LN-1:0] wt_a[$];
    longint             s [NP];
    exp_t               e;
    int                 d0, n, gap;
    d0 = done_total;
    rdy_mode = rdy;
    stall_left = (rdy == 2) ? 3 : 0;
    start_job(wl, nw, sh, rm);
    for (int win = 0; win < nw; win++) begin
      ifm_a.delete();
      wt_a.delete();
      for (int p = 0; p < NP; p++) s[p] = 0;
      for (int w = 0; w < wl; w++) begin
        ifm_a.push_back(gen_ifm(pat));
        wt_a.push_back(gen_wt(pat));
        for (int p = 0; p < NP; p++)
          for (int i = 0; i < LN; i++)
            s[p] += longint'($signed(ifm_a[w][i*8 +: 8])) * longint'($signed(wt_a[w][p*32 + i*8 +: 8]));
      end
      for (int p = 0; p < NP; p++) begin
        e.data = ref_act(s[p], sh, rm);
        e.ch   = 2'(p);
        e.last = (win == nw - 1) && (p == NP - 1);
        exp_q.push_back(e);
      end
      for (int w = 0; w < wl; w++) begin
        if (pat == 0) begin
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            in_valid = 1'b0; ifm_word = $urandom;
            start = 1'b1; win_len = 16'd0; num_win = CW'($urandom);
            repeat (gap) @(posedge clk);
            #1;
            start = 1'b0;
          end
        end
        drive_word(ifm_a[w], wt_a[w]);
      end
    end
    in_valid = 1'b0;
    ifm_word = $urandom;
    n = 0;
    while (done_total == d0 && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(done_total == d0 + 1, "done_pulse_count", done_total - d0, 1);
    chk(done_cyc == last_acc_cyc + 1, "done_after_last_accept", done_cyc - last_acc_cyc, 1);
    chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    chk(busy == 1'b0, "idle_after_done", busy, 0);
  endtask

  task automatic zero_job(input int wl, input int nw);
    int d0;
    bit active;
    d0 = done_total;
    active = 1'b0;
    start_job(wl, nw, 0, 6);
    repeat (4) begin
      if (ofm_valid || in_ready) active = 1'b1;
      @(posedge clk);
      #2;
    end
    chk(!active, "zero_job_no_activity", active, 0);
    chk(done_total == d0 + 1, "zero_job_done", done_total - d0, 1);
    chk(busy == 1'b0, "zero_job_idle", busy, 0);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_job(1, 1, 0, 6, 1, 0);      // basic: 0,4,8,12 before activation
    run_job(3, 1, 0, 6, 2, 0);      // 12 on every channel
    run_job(3, 1, 0, 255, 2, 0);
    run_job(1, 1, 0, 6, 3, 0);      // acc = -8
    run_job(1, 1, 0, 6, 4, 0);      // acc = +300
    run_job(1, 1, 4, 6, 5, 0);      // 100 >>> 4 = 6
    run_job(1, 1, 0, 5, 5, 0);
    run_job(2, 2, 8, 255, 0, 2);    // stall mid-drain, two windows
    run_job(3, 2, 0, 6, 2, 2);
    zero_job(0, 3);
    zero_job(4, 0);

    // Reset in the middle of a 5-word window.
    rdy_mode = 0;
    start_job(5, 1, 0, 6);
    drive_word(gen_ifm(0), gen_wt(0));
    drive_word(gen_ifm(0), gen_wt(0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midjob_reset");
    d0 = done_total;
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk(done_total == d0, "no_done_after_reset", done_total - d0, 0);
    run_job(3, 2, 2, 200, 0, 1);

    repeat (6) run_job($urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(4, 14),
                       $urandom_range(0, 255), 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
